// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register map, gateway
// state encoding and the priority helper used for CLAIM readback.
package intc_pkg;

   localparam logic [31:0] INTC_BASE_DEF = 32'hffff0040;

   localparam logic [31:0] INTC_PEND  = 32'h0000_0000;
   localparam logic [31:0] INTC_ENAB  = 32'h0000_0004;
   localparam logic [31:0] INTC_CLAIM = 32'h0000_0008;
   localparam logic [31:0] INTC_COMPL = 32'h0000_000c;
   localparam logic [31:0] INTC_TYPE  = 32'h0000_0010;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] PEND   = 2'd1;
   localparam logic [1:0] ACTIVE = 2'd2;

   // Lowest set bit wins; returns index+1, or 0 when nothing is set.
   function automatic logic [31:0] first_id(input logic [31:0] v);
      logic [31:0] id;
      id = '0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) id = 32'(i + 1);
      end
      return id;
   endfunction

endpackage

// File: rtl/intc_if.sv
// Bus and interrupt-line bundle between the system and the interrupt
// controller. The bidirectional data bus is a plain port on the controller.
// Handshake: a write happens on every clk edge where mem_we is high and
// mem_addr hits a register; reads need no strobe and are combinational.
interface intc_if #(parameter int N_SRC = 8);
   logic             mem_we;
   logic [31:0]      mem_addr;
   logic [N_SRC-1:0] src;
   logic             irq;

   modport master (output mem_we, output mem_addr, output src, input irq);
   modport slave  (input mem_we, input mem_addr, input src, output irq);
endinterface

// File: rtl/intc_gateway.sv
// Per-source gateway: trigger detection (edge or level), the
// IDLE/PEND/ACTIVE state machine and the sticky re-pend flag for edges
// that arrive while the source is in service.
module intc_gateway
   import intc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       src,
   input  logic       edge_type,
   input  logic       enab,
   input  logic       claim_hit,
   input  logic       compl_hit,
   input  logic       w1c_hit,
   output logic       pend,
   output logic       active,
   output logic [1:0] state_dbg
);

   logic [1:0] state;
   logic       repend;
   logic       src_q;
   logic       trig;
   logic       edge_trig;

   // Edge history; also loaded during reset so a line held high across
   // reset release is not seen as a fresh edge.
   always_ff @(posedge clk) begin
      src_q <= src;
   end

   assign edge_trig = edge_type & src & ~src_q;
   assign trig      = edge_type ? edge_trig : src;

   // Gateway state machine; a trigger in the same cycle as W1C keeps the bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         repend <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (trig) state <= PEND;
            end
            PEND: begin
               if (claim_hit && enab) begin
                  state <= ACTIVE;
                  if (edge_trig) repend <= 1'b1;
               end else if (w1c_hit && !trig) begin
                  state <= IDLE;
               end
            end
            ACTIVE: begin
               if (compl_hit) begin
                  state  <= (repend || edge_trig) ? PEND : IDLE;
                  repend <= 1'b0;
               end else if (edge_trig) begin
                  repend <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign pend      = (state == PEND);
   assign active    = (state == ACTIVE);
   assign state_dbg = state;

endmodule

// File: rtl/intc_ctrl.sv
// Memory-mapped interrupt controller: register decode, per-source
// gateways, fixed-priority claim id, registered irq and the tri-state
// read path onto the shared data bus.
module intc_ctrl
   import intc_pkg::*;
#(
   parameter int          N_SRC     = 8,
   parameter logic [31:0] INTC_BASE = INTC_BASE_DEF
)
(
   input  logic               clk,
   input  logic               rst,
   intc_if.slave              bus,
   inout  wire  [31:0]        mem_data,
   output logic [2*N_SRC-1:0] dbg_state
);

   logic [N_SRC-1:0] enab;
   logic [N_SRC-1:0] etype;
   logic [N_SRC-1:0] pend;
   logic [N_SRC-1:0] active;
   logic [N_SRC-1:0] claim_hit;
   logic [N_SRC-1:0] compl_hit;
   logic [N_SRC-1:0] w1c_hit;
   logic             sel_pend, sel_enab, sel_claim, sel_compl, sel_type;
   logic             rd_hit;
   logic [31:0]      rdata;
   logic [31:0]      claim_id;

   assign sel_pend  = (bus.mem_addr == (INTC_BASE | INTC_PEND));
   assign sel_enab  = (bus.mem_addr == (INTC_BASE | INTC_ENAB));
   assign sel_claim = (bus.mem_addr == (INTC_BASE | INTC_CLAIM));
   assign sel_compl = (bus.mem_addr == (INTC_BASE | INTC_COMPL));
   assign sel_type  = (bus.mem_addr == (INTC_BASE | INTC_TYPE));

   assign claim_id = first_id(32'(pend & enab));

   // Per-source write strobes; ids outside 1..N_SRC match nothing.
   always_comb begin
      claim_hit = '0;
      compl_hit = '0;
      w1c_hit   = '0;
      for (int i = 0; i < N_SRC; i++) begin
         claim_hit[i] = bus.mem_we && sel_claim && (mem_data == 32'(i + 1));
         compl_hit[i] = bus.mem_we && sel_compl && (mem_data == 32'(i + 1));
         w1c_hit[i]   = bus.mem_we && sel_pend  && mem_data[i];
      end
   end

   // Enable and trigger-type registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         enab  <= '0;
         etype <= '0;
      end else begin
         if (bus.mem_we && sel_enab) enab  <= mem_data[N_SRC-1:0];
         if (bus.mem_we && sel_type) etype <= mem_data[N_SRC-1:0];
      end
   end

   for (genvar i = 0; i < N_SRC; i++) begin : g_gw
      intc_gateway u_gw (
         .clk       (clk),
         .rst       (rst),
         .src       (bus.src[i]),
         .edge_type (etype[i]),
         .enab      (enab[i]),
         .claim_hit (claim_hit[i]),
         .compl_hit (compl_hit[i]),
         .w1c_hit   (w1c_hit[i]),
         .pend      (pend[i]),
         .active    (active[i]),
         .state_dbg (dbg_state[2*i +: 2])
      );
   end

   // Registered interrupt request: any pending source that is enabled.
   always_ff @(posedge clk) begin
      if (rst) bus.irq <= 1'b0;
      else     bus.irq <= |(pend & enab);
   end

   // Combinational, side-effect-free register readback.
   always_comb begin
      rdata  = '0;
      rd_hit = 1'b1;
      if (sel_pend)       rdata[N_SRC-1:0] = pend;
      else if (sel_enab)  rdata[N_SRC-1:0] = enab;
      else if (sel_claim) rdata            = claim_id;
      else if (sel_compl) rdata[N_SRC-1:0] = active;
      else if (sel_type)  rdata[N_SRC-1:0] = etype;
      else                rd_hit           = 1'b0;
   end

   assign mem_data = (!rst && !bus.mem_we && rd_hit) ? rdata : 'z;

endmodule

// File: tb/tb_intc_ctrl.sv
// Directed bench for intc_ctrl with hand-computed expectations.
module tb_intc_ctrl;
   import intc_pkg::*;

   localparam int          N    = 8;
   localparam logic [31:0] BASE = 32'hffff0040;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   wire  [31:0]     mem_data;
   logic            tb_drv = 1'b0;
   logic [31:0]     tb_wdata = '0;
   logic [2*N-1:0]  dbg_state;
   int              checks = 0;
   int              failures = 0;

   intc_if #(.N_SRC(N)) bus ();

   pullup (mem_data);
   assign mem_data = tb_drv ? tb_wdata : 'z;

   intc_ctrl #(.N_SRC(N), .INTC_BASE(BASE)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .mem_data  (mem_data),
      .dbg_state (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // One-cycle bus write, captured at the posedge inside the task.
   task automatic wr(input logic [31:0] off, input logic [31:0] d);
      bus.mem_we   = 1'b1;
      bus.mem_addr = BASE | off;
      tb_wdata     = d;
      tb_drv       = 1'b1;
      @(negedge clk);
      bus.mem_we   = 1'b0;
      tb_drv       = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
      bus.mem_addr = BASE | off;
      bus.mem_we   = 1'b0;
      #1;
      check(tag, mem_data, exp);
   endtask

   task automatic irq_chk(input string tag, input logic exp);
      check(tag, {31'd0, bus.irq}, {31'd0, exp});
   endtask

   initial begin
      bus.mem_we   = 1'b0;
      bus.mem_addr = BASE;
      bus.src      = 8'hff;
      rst          = 1'b1;
      repeat (3) tick();
      irq_chk("irq_in_rst", 1'b0);
      rst = 1'b0;
      rd_chk("pend_rst", INTC_PEND, 32'h0);
      rd_chk("enab_rst", INTC_ENAB, 32'h0);

      // level sources held high: pending but not enabled
      tick();
      rd_chk("pend_lvl", INTC_PEND, 32'hff);
      irq_chk("irq_dis", 1'b0);
      rd_chk("claim_none", INTC_CLAIM, 32'h0);
      wr(INTC_ENAB, 32'h1);
      irq_chk("irq_lat0", 1'b0);
      tick();
      irq_chk("irq_lat1", 1'b1);
      rd_chk("claim_1", INTC_CLAIM, 32'h1);
      bus.src = 8'h00;
      wr(INTC_PEND, 32'hff);
      rd_chk("pend_w1c", INTC_PEND, 32'h0);
      wr(INTC_TYPE, 32'h1);
      rd_chk("type_rb", INTC_TYPE, 32'h1);
      irq_chk("irq_w1c", 1'b0);

      // edge source 0: pulse, claim, complete
      bus.src = 8'h01; tick(); bus.src = 8'h00;
      rd_chk("pend_edge", INTC_PEND, 32'h1);
      irq_chk("irq_e0", 1'b0);
      tick();
      irq_chk("irq_e1", 1'b1);
      wr(INTC_CLAIM, 32'h1);
      rd_chk("compl_act", INTC_COMPL, 32'h1);
      rd_chk("pend_clm", INTC_PEND, 32'h0);
      irq_chk("irq_clm0", 1'b1);
      tick();
      irq_chk("irq_clm1", 1'b0);
      wr(INTC_COMPL, 32'h1);
      rd_chk("compl_done", INTC_COMPL, 32'h0);

      // edge while active re-pends on complete
      bus.src = 8'h01; tick(); bus.src = 8'h00;
      wr(INTC_CLAIM, 32'h1);
      rd_chk("compl_act2", INTC_COMPL, 32'h1);
      bus.src = 8'h01; tick(); bus.src = 8'h00; tick();
      rd_chk("pend_repend", INTC_PEND, 32'h0);
      rd_chk("compl_still", INTC_COMPL, 32'h1);
      irq_chk("irq_act", 1'b0);
      wr(INTC_COMPL, 32'h1);
      rd_chk("pend_after_compl", INTC_PEND, 32'h1);
      rd_chk("compl_clr", INTC_COMPL, 32'h0);
      irq_chk("irq_re0", 1'b0);
      tick();
      irq_chk("irq_re1", 1'b1);
      wr(INTC_PEND, 32'h1);
      rd_chk("pend_clr2", INTC_PEND, 32'h0);

      // priority between sources 2 and 3
      wr(INTC_ENAB, 32'h0c);
      wr(INTC_TYPE, 32'h0d);
      bus.src = 8'h0c; tick(); bus.src = 8'h00;
      rd_chk("claim_3", INTC_CLAIM, 32'h3);
      wr(INTC_CLAIM, 32'h3);
      rd_chk("claim_4", INTC_CLAIM, 32'h4);
      rd_chk("pend_34", INTC_PEND, 32'h08);
      rd_chk("compl_3", INTC_COMPL, 32'h04);
      wr(INTC_COMPL, 32'h3);
      wr(INTC_CLAIM, 32'h4);
      wr(INTC_COMPL, 32'h4);
      rd_chk("compl_34_done", INTC_COMPL, 32'h0);
      rd_chk("pend_34_done", INTC_PEND, 32'h0);

      // ignored operations
      wr(INTC_CLAIM, 32'h5);
      rd_chk("claim5_compl", INTC_COMPL, 32'h0);
      rd_chk("claim5_pend", INTC_PEND, 32'h0);
      bus.src = 8'h02; tick(); bus.src = 8'h00;
      rd_chk("pend_dis", INTC_PEND, 32'h02);
      wr(INTC_CLAIM, 32'h2);
      rd_chk("claim_dis_compl", INTC_COMPL, 32'h0);
      rd_chk("claim_dis_pend", INTC_PEND, 32'h02);
      bus.src = 8'h04; tick(); bus.src = 8'h00;
      wr(INTC_CLAIM, 32'h3);
      rd_chk("act_3", INTC_COMPL, 32'h04);
      wr(INTC_COMPL, 32'h0);
      rd_chk("compl0_ign", INTC_COMPL, 32'h04);
      wr(INTC_COMPL, 32'h9);
      rd_chk("compl9_ign", INTC_COMPL, 32'h04);
      wr(INTC_CLAIM, 32'h0);
      rd_chk("claim0_ign", INTC_COMPL, 32'h04);
      wr(INTC_COMPL, 32'h2);
      rd_chk("compl_nonact_pend", INTC_PEND, 32'h02);
      rd_chk("compl_nonact_act", INTC_COMPL, 32'h04);
      rd_chk("unmapped", 32'h14, 32'hffffffff);
      wr(INTC_COMPL, 32'h3);
      wr(INTC_PEND, 32'h2);
      rd_chk("clean_pend", INTC_PEND, 32'h0);
      rd_chk("clean_compl", INTC_COMPL, 32'h0);

      // W1C and edge trigger in the same cycle
      wr(INTC_ENAB, 32'h0d);
      bus.src = 8'h01; tick(); bus.src = 8'h00; tick();
      bus.src = 8'h01;
      wr(INTC_PEND, 32'h1);
      bus.src = 8'h00;
      rd_chk("w1c_vs_trig", INTC_PEND, 32'h1);
      wr(INTC_PEND, 32'h1);
      rd_chk("w1c_plain", INTC_PEND, 32'h0);

      // reset while active
      bus.src = 8'h01; tick(); bus.src = 8'h00;
      wr(INTC_CLAIM, 32'h1);
      rd_chk("pre_rst_act", INTC_COMPL, 32'h1);
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      rd_chk("rst_pend", INTC_PEND, 32'h0);
      rd_chk("rst_enab", INTC_ENAB, 32'h0);
      rd_chk("rst_type", INTC_TYPE, 32'h0);
      rd_chk("rst_compl", INTC_COMPL, 32'h0);
      rd_chk("rst_claim", INTC_CLAIM, 32'h0);
      check("rst_state", 32'(dbg_state), 32'h0);
      irq_chk("rst_irq0", 1'b0);
      tick();
      irq_chk("rst_irq1", 1'b0);
      rd_chk("rst_compl1", INTC_COMPL, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
